// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment display peripheral: register map,
// hex-to-segment table and reset values.
package seg7_pkg;

  localparam logic [1:0] SEG_ADDR_LO   = 2'b00;
  localparam logic [1:0] SEG_ADDR_MASK = 2'b01;
  localparam logic [1:0] SEG_ADDR_HI   = 2'b10;

  // Active-high gfedcba patterns, index = nibble value (entry 0 is rightmost)
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  localparam logic [31:0] VAL_RST = 32'h0000_0000;
  localparam logic [7:0]  EN_RST  = 8'hFF;
  localparam logic [7:0]  DP_RST  = 8'h00;
  localparam logic [7:0]  DARK    = 8'hFF;

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational nibble to active-high gfedcba segment pattern.
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_SEG[nib_i];

endmodule

// File: rtl/seg7_io_display.sv
// Memory-mapped 8-digit hex 7-segment display with time-multiplexed outputs.
// Optional leading-zero suppression is enabled by defining SEG7_ZERO_BLANK_EN.
module seg7_io_display
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int NDIG     = 8
) (
  input  logic            seg_clk,
  input  logic            seg_rst_n,
  input  logic            segwrite,
  input  logic            segcs,
  input  logic [1:0]      segaddr,
  input  logic [15:0]     segwdata,
  output logic [NDIG-1:0] DIG,
  output logic [7:0]      Y
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int SW = $clog2(NDIG);

  logic [4*NDIG-1:0] val_q;
  logic [NDIG-1:0]   en_q, dp_q;
  logic [PW-1:0]     presc_q;
  logic [SW-1:0]     scan_q;
  logic [NDIG-1:0]   dig_q, dig_d;
  logic [7:0]        y_q, y_d;
  logic [3:0]        nib;
  logic [6:0]        seg;
  logic              blank, lit;

  always_ff @(posedge seg_clk or negedge seg_rst_n) begin
    if (!seg_rst_n) begin
      val_q <= VAL_RST;
      en_q  <= EN_RST;
      dp_q  <= DP_RST;
    end else if (segcs && segwrite) begin
      case (segaddr)
        SEG_ADDR_LO:   val_q[15:0]  <= segwdata;
        SEG_ADDR_HI:   val_q[31:16] <= segwdata;
        SEG_ADDR_MASK: begin
          en_q <= segwdata[7:0];
          dp_q <= segwdata[15:8];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge seg_clk or negedge seg_rst_n) begin
    if (!seg_rst_n) begin
      presc_q <= '0;
      scan_q  <= '0;
    end else if (presc_q == PW'(SCAN_DIV - 1)) begin
      presc_q <= '0;
      scan_q  <= scan_q + 1'b1;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  assign nib = val_q[{scan_q, 2'b00} +: 4];

  seg7_hex_decoder u_dec (
    .nib_i (nib),
    .seg_o (seg)
  );

`ifdef SEG7_ZERO_BLANK_EN
  // Blank every digit above the most significant non-zero nibble; digit 0 always survives.
  logic [SW-1:0] top_nz;
  always_comb begin
    top_nz = '0;
    for (int i = 1; i < NDIG; i++)
      if (val_q[4*i +: 4] != 4'h0) top_nz = SW'(i);
  end
  assign blank = (scan_q > top_nz);
`else
  assign blank = 1'b0;
`endif

  assign lit = en_q[scan_q] && !blank;

  always_comb begin
    dig_d = {NDIG{1'b1}};
    y_d   = DARK;
    if (lit) begin
      dig_d = ~(NDIG'(1) << scan_q);
      y_d   = {~dp_q[scan_q], ~seg};
    end
  end

  always_ff @(posedge seg_clk or negedge seg_rst_n) begin
    if (!seg_rst_n) begin
      dig_q <= {NDIG{1'b1}};
      y_q   <= DARK;
    end else begin
      dig_q <= dig_d;
      y_q   <= y_d;
    end
  end

  assign DIG = dig_q;
  assign Y   = y_q;

endmodule

// File: tb/tb_seg7_io_display.sv
// Directed, table-driven bench for seg7_io_display with SCAN_DIV=4.
module tb_seg7_io_display;

  logic        seg_clk = 1'b0;
  logic        seg_rst_n = 1'b0;
  logic        segwrite = 1'b0;
  logic        segcs = 1'b0;
  logic [1:0]  segaddr = 2'b00;
  logic [15:0] segwdata = 16'h0000;
  logic [7:0]  DIG, Y;

  seg7_io_display #(.SCAN_DIV(4), .NDIG(8)) dut (
    .seg_clk   (seg_clk),
    .seg_rst_n (seg_rst_n),
    .segwrite  (segwrite),
    .segcs     (segcs),
    .segaddr   (segaddr),
    .segwdata  (segwdata),
    .DIG       (DIG),
    .Y         (Y)
  );

  always #5 seg_clk = ~seg_clk;

  typedef struct {
    bit        wr;
    bit        cs;
    bit [1:0]  addr;
    bit [15:0] data;
    int        digit;
    bit [7:0]  dig;
    bit [7:0]  y;
    string     name;
  } vec_t;

  vec_t vecs[15];
  int   total = 0;
  int   passed = 0;
  int   k = 0;   // rising edges since last reset release

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else passed++;
  endtask

  task automatic tick();
    @(posedge seg_clk);
    #1;
    k++;
  endtask

  function automatic int slot();
    return ((k - 1) / 4) % 8;
  endfunction

  task automatic do_write(input bit wr, input bit cs, input bit [1:0] a, input bit [15:0] d);
    segwrite = wr; segcs = cs; segaddr = a; segwdata = d;
    tick();
    segwrite = 1'b0; segcs = 1'b0;
  endtask

  task automatic goto_digit(input int d, input string nm);
    int n = 0;
    do begin tick(); n++; end while (slot() != d && n < 64);
    if (n >= 64) begin total++; $display("FAIL %s: slot %0d never reached", nm, d); end
  endtask

  task automatic do_reset();
    seg_rst_n = 1'b0;
    #1;
    chk("rst_dig", DIG, 8'hFF);
    chk("rst_y", Y, 8'hFF);
    @(posedge seg_clk); @(posedge seg_clk);
    #1;
    chk("rst_hold_dig", DIG, 8'hFF);
    seg_rst_n = 1'b1;
    k = 0;
  endtask

  initial begin
    vecs[0]  = '{1, 1, 2'b00, 16'h5678, 0, 8'hFE, 8'h80, "lo_d0"};
    vecs[1]  = '{1, 1, 2'b10, 16'h1234, 7, 8'h7F, 8'hF9, "hi_d7"};
    vecs[2]  = '{0, 0, 2'b00, 16'h0000, 1, 8'hFD, 8'hF8, "d1"};
    vecs[3]  = '{0, 0, 2'b00, 16'h0000, 2, 8'hFB, 8'h82, "d2"};
    vecs[4]  = '{0, 0, 2'b00, 16'h0000, 3, 8'hF7, 8'h92, "d3"};
    vecs[5]  = '{0, 0, 2'b00, 16'h0000, 4, 8'hEF, 8'h99, "d4"};
    vecs[6]  = '{0, 0, 2'b00, 16'h0000, 5, 8'hDF, 8'hB0, "d5"};
    vecs[7]  = '{0, 0, 2'b00, 16'h0000, 6, 8'hBF, 8'hA4, "d6"};
    vecs[8]  = '{1, 1, 2'b01, 16'h8003, 0, 8'hFE, 8'h80, "mask_d0"};
    vecs[9]  = '{0, 0, 2'b00, 16'h0000, 7, 8'hFF, 8'hFF, "mask_d7_dark"};
    vecs[10] = '{0, 0, 2'b00, 16'h0000, 1, 8'hFD, 8'hF8, "mask_d1"};
    vecs[11] = '{1, 1, 2'b01, 16'h01FF, 0, 8'hFE, 8'h00, "dp_d0"};
    vecs[12] = '{1, 1, 2'b11, 16'hFFFF, 3, 8'hF7, 8'h92, "addr11_ign"};
    vecs[13] = '{1, 0, 2'b00, 16'h0000, 0, 8'hFE, 8'h00, "nocs_ign"};
    vecs[14] = '{0, 1, 2'b00, 16'h0000, 1, 8'hFD, 8'hF8, "nowr_ign"};

    repeat (2) @(posedge seg_clk);
    #1;
    do_reset();

    // First output update after release lands on digit 0; slot lasts 4 edges
    tick();
    chk("rel_d0_dig", DIG, 8'hFE);
    chk("rel_d0_y", Y, 8'hC0);
    tick(); tick(); tick();
    chk("slot0_end_dig", DIG, 8'hFE);
    tick();
    chk("slot1_start_dig", DIG, 8'hFD);

    foreach (vecs[i]) begin
      if (vecs[i].wr || vecs[i].cs)
        do_write(vecs[i].wr, vecs[i].cs, vecs[i].addr, vecs[i].data);
      goto_digit(vecs[i].digit, vecs[i].name);
      chk({vecs[i].name, "_dig"}, DIG, vecs[i].dig);
      chk({vecs[i].name, "_y"}, Y, vecs[i].y);
    end

    // Write landing on the 7->0 scan advance edge: old digit 7 shown, then new digit 0
    do_write(1, 1, 2'b01, 16'h00FF);
    begin
      int n = 0;
      while (((k + 1) % 32) != 0 && n < 64) begin tick(); n++; end
    end
    do_write(1, 1, 2'b00, 16'hABCD);
    chk("adv_old_dig", DIG, 8'h7F);
    chk("adv_old_y", Y, 8'hF9);
    tick();
    chk("adv_new_dig", DIG, 8'hFE);
    chk("adv_new_y", Y, 8'hA1);

    // Reset in the middle of slot 5
    begin
      int n = 0;
      do begin tick(); n++; end while (!(slot() == 5 && ((k - 1) % 4) == 1) && n < 64);
      chk("pre_rst_dig", DIG, 8'hDF);
    end
    #2;
    do_reset();
    tick();
    chk("post_rst_dig", DIG, 8'hFE);
    chk("post_rst_y", Y, 8'hC0);
    goto_digit(7, "post_rst_d7");
    chk("post_rst_d7_y", Y, 8'hC0);

    // Leading-zero behaviour with val = 0x000000A0
    do_write(1, 1, 2'b00, 16'h00A0);
    goto_digit(0, "zb_d0");
    chk("zb_d0_y", Y, 8'hC0);
    goto_digit(1, "zb_d1");
    chk("zb_d1_dig", DIG, 8'hFD);
    chk("zb_d1_y", Y, 8'h88);
    goto_digit(2, "zb_d2");
`ifdef SEG7_ZERO_BLANK_EN
    chk("zb_d2_dig", DIG, 8'hFF);
    chk("zb_d2_y", Y, 8'hFF);
`else
    chk("zb_d2_dig", DIG, 8'hFB);
    chk("zb_d2_y", Y, 8'hC0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
